// File: rtl/dmem_responder.sv
// Data-memory responder for the rv_cpu core: one outstanding load/store request,
// byte-lane writes to a local array, and a single-cycle response after LATENCY wait states.
module dmem_responder #(
    parameter int DMEM_SIZE_BYTES = 1024,
    parameter int LATENCY         = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wr_data,
    input  logic        req_wr_en,
    input  logic        req_rd_en,
    input  logic [3:0]  req_byte_en,
    input  logic        req_is_signed,
    output logic        rsp_valid,
    output logic [31:0] rsp_rd_data,
    output logic        rsp_error
);
    localparam int AW = $clog2(DMEM_SIZE_BYTES);
    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] addr_q;
    logic [3:0]    be_q;
    logic          signed_q;
    logic          load_q;
    logic          err_q;

    logic [7:0]    mem [DMEM_SIZE_BYTES];

    logic          accept;
    logic          out_of_range;
    logic          legal_be;
    logic          misaligned;
    logic          err_in;
    logic          store_in;
    logic          load_in;

    logic [AW-1:0] rd_addr;
    logic [3:0]    rd_be;
    logic          rd_sgn;
    logic          rd_load;
    logic [7:0]    rd_bytes [4];
    logic [31:0]   rd_value;

    assign accept       = (state == IDLE) && req_ready && req_valid;
    assign out_of_range = req_address >= 32'(DMEM_SIZE_BYTES);
    assign legal_be     = (req_byte_en == 4'b0001) || (req_byte_en == 4'b0011) ||
                          (req_byte_en == 4'b1111);
    assign misaligned   = ((req_byte_en == 4'b0011) && req_address[0]) ||
                          ((req_byte_en == 4'b1111) && (req_address[1:0] != 2'b00));
    assign err_in       = out_of_range || !legal_be || misaligned || (req_wr_en && req_rd_en);
    assign store_in     = req_wr_en && !req_rd_en && !err_in;
    assign load_in      = req_rd_en && !req_wr_en && !err_in;

    // With LATENCY=0 the response is formed on the acceptance edge, so read from the live request.
    always_comb begin
        rd_addr = (state == IDLE) ? req_address[AW-1:0] : addr_q;
        rd_be   = (state == IDLE) ? req_byte_en : be_q;
        rd_sgn  = (state == IDLE) ? req_is_signed : signed_q;
        rd_load = (state == IDLE) ? load_in : load_q;
        for (int k = 0; k < 4; k++) begin
            rd_bytes[k] = mem[rd_addr + AW'(k)];
        end
        case (rd_be)
            4'b0001: rd_value = {{24{rd_sgn & rd_bytes[0][7]}}, rd_bytes[0]};
            4'b0011: rd_value = {{16{rd_sgn & rd_bytes[1][7]}}, rd_bytes[1], rd_bytes[0]};
            default: rd_value = {rd_bytes[3], rd_bytes[2], rd_bytes[1], rd_bytes[0]};
        endcase
        if (!rd_load) begin
            rd_value = '0;
        end
    end

    // Storage is deliberately outside the reset domain; stores commit on the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept && store_in) begin
            for (int k = 0; k < 4; k++) begin
                if (req_byte_en[k]) begin
                    mem[req_address[AW-1:0] + AW'(k)] <= req_wr_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            signed_q    <= 1'b0;
            load_q      <= 1'b0;
            err_q       <= 1'b0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rd_data <= '0;
            rsp_error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_address[AW-1:0];
                        be_q      <= req_byte_en;
                        signed_q  <= req_is_signed;
                        load_q    <= load_in;
                        err_q     <= err_in;
                        if (LATENCY == 0) begin
                            state       <= RESP;
                            rsp_valid   <= 1'b1;
                            rsp_rd_data <= rd_value;
                            rsp_error   <= err_in;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_rd_data <= rd_value;
                        rsp_error   <= err_q;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    req_ready   <= 1'b1;
                    rsp_valid   <= 1'b0;
                    rsp_rd_data <= '0;
                    rsp_error   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 0, 5) checked every cycle against a
// timestamp/byte-array model, plus literal expectations for the directed scenarios.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        wr    = 1'b0;
    logic        rd    = 1'b0;
    logic [3:0]  be    = '0;
    logic        sgn   = 1'b0;

    logic        ready  [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        rerr   [3];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DMEM_SIZE_BYTES(1024), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .req_valid(valid[0]), .req_ready(ready[0]),
        .req_address(addr), .req_wr_data(wdata), .req_wr_en(wr), .req_rd_en(rd),
        .req_byte_en(be), .req_is_signed(sgn), .rsp_valid(rvalid[0]),
        .rsp_rd_data(rdata[0]), .rsp_error(rerr[0]));

    dmem_responder #(.DMEM_SIZE_BYTES(1024), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst), .req_valid(valid[1]), .req_ready(ready[1]),
        .req_address(addr), .req_wr_data(wdata), .req_wr_en(wr), .req_rd_en(rd),
        .req_byte_en(be), .req_is_signed(sgn), .rsp_valid(rvalid[1]),
        .rsp_rd_data(rdata[1]), .rsp_error(rerr[1]));

    dmem_responder #(.DMEM_SIZE_BYTES(1024), .LATENCY(5)) u_lat5 (
        .clk(clk), .rst(rst), .req_valid(valid[2]), .req_ready(ready[2]),
        .req_address(addr), .req_wr_data(wdata), .req_wr_en(wr), .req_rd_en(rd),
        .req_byte_en(be), .req_is_signed(sgn), .rsp_valid(rvalid[2]),
        .rsp_rd_data(rdata[2]), .rsp_error(rerr[2]));

    // Model: cycle index = number of rising edges so far; the period after edge E has index E.
    int          lat [3] = '{2, 0, 5};
    logic [7:0]  mmem [3][1024];
    bit          live [3];
    int          ready_from [3];
    int          rsp_cyc [3] = '{-1, -1, -1};
    logic [31:0] exp_data [3];
    logic        exp_err [3];
    int          acc_cyc [3];

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s dut%0d: got %h, expected %h", name, d, act, exp);
        end
    endtask

    task automatic model_accept(input int d, input int e);
        int     size;
        longint val;
        bit     err;
        err  = (addr >= 32'd1024) || !(be inside {4'b0001, 4'b0011, 4'b1111}) ||
               (be == 4'b0011 && addr[0]) || (be == 4'b1111 && addr[1:0] != 2'b00) ||
               (wr && rd);
        size = (be == 4'b0001) ? 1 : (be == 4'b0011) ? 2 : 4;
        val  = 0;
        if (!err && wr) begin
            for (int i = 0; i < size; i++) mmem[d][int'(addr[9:0]) + i] = wdata[8*i +: 8];
        end
        if (!err && rd) begin
            for (int i = 0; i < size; i++)
                val += longint'(mmem[d][int'(addr[9:0]) + i]) << (8 * i);
            if (sgn && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                val -= longint'(1) << (8 * size);
        end
        exp_data[d]   = val[31:0];
        exp_err[d]    = err;
        rsp_cyc[d]    = e + lat[d];
        ready_from[d] = e + lat[d] + 1;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                live[d]    = 1'b0;
                rsp_cyc[d] = -1;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (!live[d]) begin
                    live[d]       = 1'b1;
                    ready_from[d] = cyc + 1;
                end else if (valid[d] && cyc >= ready_from[d]) begin
                    model_accept(d, cyc + 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic er;
        logic ev;
        for (int d = 0; d < 3; d++) begin
            er = rst && live[d] && (cyc >= ready_from[d]);
            ev = rst && (cyc == rsp_cyc[d]);
            check("req_ready", d, ready[d], er);
            check("rsp_valid", d, rvalid[d], ev);
            if (ev) begin
                check("rsp_rd_data", d, rdata[d], exp_data[d]);
                check("rsp_error", d, rerr[d], exp_err[d]);
            end else if (!rst) begin
                check("reset_rd_data", d, rdata[d], 32'h0);
                check("reset_error", d, rerr[d], 1'b0);
            end
        end
    end

    task automatic apply_stimulus(input int d, input logic w, input logic r, input logic [3:0] b,
                                  input logic s, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!ready[d] && n < 40);
        if (!ready[d]) check("ready_timeout", d, 32'd0, 32'd1);
        wr = w; rd = r; be = b; sgn = s; addr = a; wdata = wd;
        valid[d]   = 1'b1;
        acc_cyc[d] = cyc;
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        addr  = $urandom;
        wdata = $urandom;
        wr    = 1'($urandom);
        rd    = 1'($urandom);
        be    = 4'($urandom);
        sgn   = 1'($urandom);
    endtask

    task automatic check_output(input int d, input logic [31:0] ed, input logic ee, input int el);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (rvalid[d]) seen = 1'b1;
        end
        if (!seen) begin
            check("rsp_timeout", d, 32'd0, 32'd1);
        end else begin
            check("lit_latency", d, cyc - acc_cyc[d], el);
            check("lit_rd_data", d, rdata[d], ed);
            check("lit_error", d, rerr[d], ee);
        end
    endtask

    task automatic transact(input int d, input logic w, input logic r, input logic [3:0] b,
                            input logic s, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] ed, input logic ee);
        apply_stimulus(d, w, r, b, s, a, wd);
        check_output(d, ed, ee, lat[d] + 1);
    endtask

    initial begin
        int pulses;
        int n;

        repeat (2) @(negedge clk);
        check("reset_ready", 0, ready[0], 1'b0);
        check("reset_rsp_valid", 0, rvalid[0], 1'b0);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", 0, ready[0], 1'b1);

        // LATENCY=2: word round trip, byte lanes, sign extension
        transact(0, 1, 0, 4'b1111, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        transact(0, 0, 1, 4'b1111, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        transact(0, 1, 0, 4'b1111, 0, 32'h20, 32'h44332211, 32'h0, 0);
        transact(0, 1, 0, 4'b0001, 0, 32'h21, 32'hFFFFFF80, 32'h0, 0);
        transact(0, 0, 1, 4'b0001, 1, 32'h21, 32'h0, 32'hFFFFFF80, 0);
        transact(0, 0, 1, 4'b0001, 0, 32'h21, 32'h0, 32'h00000080, 0);
        transact(0, 0, 1, 4'b1111, 0, 32'h20, 32'h0, 32'h44338011, 0);
        transact(0, 0, 1, 4'b0011, 1, 32'h20, 32'h0, 32'hFFFF8011, 0);
        transact(0, 0, 1, 4'b0011, 1, 32'h22, 32'h0, 32'h00004433, 0);

        // Rejected requests leave memory untouched
        transact(0, 1, 0, 4'b1111, 0, 32'h30, 32'h76543210, 32'h0, 0);
        transact(0, 1, 0, 4'b0011, 0, 32'h31, 32'h0000AAAA, 32'h0, 1);
        transact(0, 0, 1, 4'b1111, 0, 32'h42, 32'h0, 32'h0, 1);
        transact(0, 1, 0, 4'b0001, 0, 32'h400, 32'h000000EE, 32'h0, 1);
        transact(0, 1, 1, 4'b1111, 0, 32'h20, 32'h55555555, 32'h0, 1);
        transact(0, 0, 1, 4'b0111, 0, 32'h20, 32'h0, 32'h0, 1);
        transact(0, 0, 1, 4'b1111, 0, 32'h30, 32'h0, 32'h76543210, 0);
        transact(0, 0, 1, 4'b1111, 0, 32'h20, 32'h0, 32'h44338011, 0);
        transact(0, 0, 0, 4'b1111, 0, 32'h10, 32'h0, 32'h0, 0);

        // LATENCY=0: back-to-back valid gives an accept every second cycle
        transact(1, 1, 0, 4'b1111, 0, 32'h8, 32'h12345678, 32'h0, 0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!ready[1] && n < 40);
        wr = 1'b0; rd = 1'b1; be = 4'b1111; sgn = 1'b0; addr = 32'h8; wdata = 32'h0;
        valid[1] = 1'b1;
        pulses   = 0;
        repeat (8) begin
            @(negedge clk);
            if (rvalid[1]) pulses++;
        end
        #1 valid[1] = 1'b0;
        check("b2b_pulses", 1, pulses, 32'd4);

        // LATENCY=5: reset in the middle of a load aborts it
        transact(2, 1, 0, 4'b1111, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0);
        apply_stimulus(2, 0, 1, 4'b1111, 0, 32'h40, 32'h0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", 2, ready[2], 1'b0);
            check("rst_rsp_valid", 2, rvalid[2], 1'b0);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_after_abort", 2, ready[2], 1'b1);
        repeat (8) @(negedge clk);
        transact(2, 0, 1, 4'b1111, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0);
        transact(2, 0, 1, 4'b0011, 1, 32'h42, 32'h0, 32'hFFFFCAFE, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the rv_cpu pipeline: the memory end of the core's data request interface. It accepts one load or store request at a time through a valid/ready handshake and applies byte-lane writes to a local byte array. After a programmable wait-state latency it returns a one-cycle response with sign- or zero-extended load data and an error flag. It sits between the core's memory-access stage and data storage, so the bench can exercise stall behaviour that a zero-latency memory never produces.

## Interface
Parameters:
- DMEM_SIZE_BYTES, 1024: byte capacity; must be a power of two, at least 4.
- LATENCY, 2: wait-state cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder idle and able to accept.
- req_address  in  32  byte address.
- req_wr_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_wr_en  in  1  store request.
- req_rd_en  in  1  load request.
- req_byte_en  in  4  access size: 4'b0001 byte, 4'b0011 half, 4'b1111 word.
- req_is_signed  in  1  sign-extend load data (1) or zero-extend (0).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rd_data  out  32  load result; 0 for stores, no-ops and errors.
- rsp_error  out  1  request was rejected; qualified by rsp_valid.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Accept when req_valid=1. Go to WAIT if LATENCY>0, else to RESP.
  - WAIT: a 4-bit counter loads LATENCY-1 at acceptance and decrements each cycle. Go to RESP when the counter reaches 0.
  - RESP: rsp_valid=1 for exactly one cycle, then return to IDLE.
- On acceptance, register address, data, byte_en, is_signed and the opcode. Later changes on the request inputs have no effect.
- Error conditions, evaluated at acceptance:
  - address >= DMEM_SIZE_BYTES;
  - byte_en not one of the three legal codes;
  - half access with address[0]=1;
  - word access with address[1:0]!=0;
  - wr_en and rd_en both set.
- An errored request does not write memory and returns rsp_rd_data=0, rsp_error=1.
- Store: on the acceptance edge, write the low 1/2/4 bytes of req_wr_data to addresses addr..addr+size-1, little-endian. Bytes outside the access are unchanged.
- Load: read the bytes on the edge entering RESP and hold them in the response register.
  - Byte loads extend from bit 7, half loads from bit 15, per is_signed.
  - Word loads pass through unchanged.
- Valid with neither wr_en nor rd_en set is a no-op: full handshake, rsp_rd_data=0, rsp_error=0.
- The response has no backpressure; the core always samples it in the RESP cycle.
- Memory contents are not cleared by reset.

## Timing
- Acceptance edge T (IDLE, req_valid=1): rsp_valid is high during cycle T+1+LATENCY.
- req_ready is low from T+1 until the cycle after RESP.
- Maximum throughput is one request per LATENCY+2 cycles.
- A load issued after a store observes the stored data, because there is only one outstanding request.
- Reset values while rst=0: state IDLE, req_ready=0, rsp_valid=0, rsp_rd_data=0, rsp_error=0, counter=0.
- req_ready first rises on the first rising edge after rst deasserts.
- Reset during WAIT or RESP aborts the transaction immediately. rsp_valid drops asynchronously and no response is produced. A store accepted before the reset edge remains written.
- req_valid during WAIT or RESP is ignored; the core must hold the request until it sees req_ready=1.

## Test plan
- LATENCY=2: store word 0xDEADBEEF to 0x10, then load word 0x10. Each rsp_valid occurs exactly 3 cycles after its accept. The load returns 0xDEADBEEF with error=0.
- Store byte 0x80 to 0x21, then:
  - signed byte load from 0x21 returns 0xFFFFFF80;
  - unsigned byte load returns 0x00000080;
  - bytes 0x20, 0x22 and 0x23 are unchanged.
- Half at 0x31, word at 0x42, address 0x400 (size 1024), and wr_en+rd_en together each give rsp_error=1 and rsp_rd_data=0, with memory unchanged.
- LATENCY=0 with back-to-back req_valid: accepts occur every 2 cycles, and rsp_valid follows each accept by one cycle.
- Assert rst in the middle of a LATENCY=5 load (WAIT state): rsp_valid stays 0 and req_ready=0 during reset. req_ready=1 one edge after release, and the next load completes normally.
- No-op request (valid, no wr/rd) returns rsp_valid with data 0 and error 0. Request inputs toggled during WAIT do not alter the response.
